// File: rtl/text_pkg.sv
// Shared types and constants for the text line buffer feeding the ASCII glyph renderer.
package text_pkg;

  localparam int NUM_CHARS_DEFAULT    = 41;
  localparam int BLINK_FRAMES_DEFAULT = 30;

  typedef logic [7:0] char_t;

  localparam char_t ASCII_BS     = 8'h08;
  localparam char_t ASCII_CR     = 8'h0D;
  localparam char_t ASCII_LF     = 8'h0A;
  localparam char_t ASCII_SPACE  = 8'h20;
  localparam char_t GLYPH_FIRST  = 8'h30;
  localparam char_t GLYPH_LAST   = 8'h5A;
  localparam char_t LOWER_FIRST  = 8'h61;
  localparam char_t LOWER_LAST   = 8'h7A;
  localparam char_t CASE_OFFSET  = 8'h20;
  localparam char_t CURSOR_GLYPH = 8'h5F;
  localparam char_t BLANK_CODE   = 8'h00;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

endpackage

// File: rtl/ascii_filter.sv
// Combinational classifier: maps an incoming ASCII byte to a stored glyph code
// or to one of the editing commands (backspace, clear line).
module ascii_filter
  import text_pkg::*;
(
  input  char_t data,
  output logic  store,
  output char_t code,
  output logic  is_bs,
  output logic  is_clear
);

  // Lowercase folds onto uppercase glyphs; space is stored as the blank code.
  always_comb begin
    store    = 1'b0;
    code     = BLANK_CODE;
    is_bs    = 1'b0;
    is_clear = 1'b0;
    if (data >= GLYPH_FIRST && data <= GLYPH_LAST) begin
      store = 1'b1;
      code  = data;
    end else if (data >= LOWER_FIRST && data <= LOWER_LAST) begin
      store = 1'b1;
      code  = data - CASE_OFFSET;
    end else if (data == ASCII_SPACE) begin
      store = 1'b1;
      code  = BLANK_CODE;
    end else if (data == ASCII_BS) begin
      is_bs = 1'b1;
    end else if (data == ASCII_CR || data == ASCII_LF) begin
      is_clear = 1'b1;
    end else begin
      store = 1'b0;
    end
  end

endmodule

// File: rtl/text_line_buffer.sv
// Double-buffered text line: edits go to a working copy, char_out is refreshed only at frame start.
// Optional cursor blink overlay enabled by defining TEXT_CURSOR_BLINK_EN.
module text_line_buffer
  import text_pkg::*;
#(
  parameter int NUM_CHARS = NUM_CHARS_DEFAULT
`ifdef TEXT_CURSOR_BLINK_EN
  ,
  parameter int BLINK_FRAMES = BLINK_FRAMES_DEFAULT
`endif
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  input  logic [7:0]                  in_data,
  output logic                        in_ready,
  input  logic                        frame_start,
  output char_t [NUM_CHARS-1:0]       char_out,
  output logic [5:0]                  cursor,
  output logic                        line_full
);

  localparam logic [5:0] LAST_IDX = 6'(NUM_CHARS - 1);
  localparam logic [5:0] FULL_POS = 6'(NUM_CHARS);

  state_t                state;
  state_t                state_nx;
  logic [5:0]            clr_idx;
  logic [5:0]            clr_idx_nx;
  logic [5:0]            cursor_nx;
  char_t [NUM_CHARS-1:0] working;
  char_t [NUM_CHARS-1:0] working_nx;
  char_t [NUM_CHARS-1:0] disp_nx;
  logic                  pending;
  logic                  pending_nx;
  logic                  commit;
  logic                  xfer;
  logic                  f_store;
  char_t                 f_code;
  logic                  f_is_bs;
  logic                  f_is_clear;

  ascii_filter u_filter (
    .data     (in_data),
    .store    (f_store),
    .code     (f_code),
    .is_bs    (f_is_bs),
    .is_clear (f_is_clear)
  );

  assign xfer = in_valid && in_ready;

  // Edit/clear engine: next working copy, cursor and FSM state.
  always_comb begin
    state_nx   = state;
    clr_idx_nx = clr_idx;
    cursor_nx  = cursor;
    working_nx = working;
    case (state)
      IDLE: begin
        if (xfer && f_store) begin
          if (cursor != FULL_POS) begin
            working_nx[cursor] = f_code;
            cursor_nx          = cursor + 6'd1;
          end else begin
            cursor_nx = cursor;
          end
        end else if (xfer && f_is_bs) begin
          if (cursor != 6'd0) begin
            cursor_nx             = cursor - 6'd1;
            working_nx[cursor_nx] = BLANK_CODE;
          end else begin
            cursor_nx = cursor;
          end
        end else if (xfer && f_is_clear) begin
          state_nx   = CLEAR;
          clr_idx_nx = 6'd0;
        end else begin
          state_nx = IDLE;
        end
      end
      CLEAR: begin
        working_nx[clr_idx] = BLANK_CODE;
        if (clr_idx == LAST_IDX) begin
          state_nx   = IDLE;
          clr_idx_nx = 6'd0;
          cursor_nx  = 6'd0;
        end else begin
          clr_idx_nx = clr_idx + 6'd1;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // A frame pulse seen during CLEAR is held until the line is fully blank.
  always_comb begin
    commit     = (state == IDLE) && (frame_start || pending);
    pending_nx = (state == CLEAR) ? (pending || frame_start) : 1'b0;
  end

`ifdef TEXT_CURSOR_BLINK_EN
  localparam int FC_W = $clog2(BLINK_FRAMES + 1);
  localparam logic [FC_W-1:0] FC_LAST = FC_W'(BLINK_FRAMES - 1);

  logic            blink_on;
  logic [FC_W-1:0] frame_cnt;

  // Blink phase flips after every BLINK_FRAMES frame pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_on  <= 1'b1;
      frame_cnt <= '0;
    end else if (frame_start) begin
      if (frame_cnt == FC_LAST) begin
        frame_cnt <= '0;
        blink_on  <= !blink_on;
      end else begin
        frame_cnt <= frame_cnt + FC_W'(1);
      end
    end
  end

  // Cursor glyph is overlaid on the display copy only; working stays untouched.
  always_comb begin
    disp_nx = working_nx;
    if (blink_on && cursor_nx != FULL_POS) begin
      disp_nx[cursor_nx] = CURSOR_GLYPH;
    end else begin
      disp_nx = working_nx;
    end
  end
`else
  assign disp_nx = working_nx;
`endif

  // State, working copy, display copy and status registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      clr_idx   <= 6'd0;
      working   <= '0;
      char_out  <= '0;
      cursor    <= 6'd0;
      line_full <= 1'b0;
      in_ready  <= 1'b0;
      pending   <= 1'b0;
    end else begin
      state     <= state_nx;
      clr_idx   <= clr_idx_nx;
      working   <= working_nx;
      cursor    <= cursor_nx;
      line_full <= (cursor_nx == FULL_POS);
      in_ready  <= (state_nx == IDLE);
      pending   <= pending_nx;
      if (commit) begin
        char_out <= disp_nx;
      end
    end
  end

endmodule

// File: tb/tb_text_line_buffer.sv
// Directed bench for text_line_buffer: table of byte/cursor vectors plus hand sequences for clear, fill and reset.
module tb_text_line_buffer;

  localparam int N = 41;

  logic              clk;
  logic              rst_n;
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              frame_start;
  logic [N-1:0][7:0] char_out;
  logic [5:0]        cursor;
  logic              line_full;

  int total;
  int bad;

  text_line_buffer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .frame_start (frame_start),
    .char_out    (char_out),
    .cursor      (cursor),
    .line_full   (line_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic [5:0] cur;
    logic       full;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_line(input string name, input logic [N-1:0][7:0] act, input logic [N-1:0][7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic fs);
    int n;
    n = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      total++;
      bad++;
      $display("FAIL send_timeout: in_ready stuck low for byte %0h", b);
    end
    frame_start = fs;
    @(posedge clk);
    #1;
    in_valid    = 1'b0;
    frame_start = 1'b0;
  endtask

  task automatic pulse_frame();
    @(negedge clk);
    frame_start = 1'b1;
    @(posedge clk);
    #1;
    frame_start = 1'b0;
  endtask

  initial begin
    logic [N-1:0][7:0] exp_line;
    logic [N-1:0][7:0] old_line;
    int low_cnt;
    int exit_k;
    logic partial;

    total = 0;
    bad   = 0;
    tbl[0] = '{8'h20, 6'd4, 1'b0};
    tbl[1] = '{8'h7E, 6'd4, 1'b0};
    tbl[2] = '{8'h5A, 6'd5, 1'b0};
    tbl[3] = '{8'h7A, 6'd6, 1'b0};
    tbl[4] = '{8'h2F, 6'd6, 1'b0};
    tbl[5] = '{8'h5B, 6'd6, 1'b0};
    tbl[6] = '{8'h60, 6'd6, 1'b0};
    tbl[7] = '{8'h7B, 6'd6, 1'b0};
    tbl[8] = '{8'h08, 6'd5, 1'b0};
    tbl[9] = '{8'h30, 6'd6, 1'b0};

    rst_n       = 1'b0;
    in_valid    = 1'b0;
    in_data     = 8'h00;
    frame_start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_in_ready", 32'(in_ready), 32'd0);
    chk("reset_cursor", 32'(cursor), 32'd0);
    chk("reset_full", 32'(line_full), 32'd0);
    chk_line("reset_line", char_out, '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("ready_after_reset", 32'(in_ready), 32'd1);

    // "ab1": display must not change until the frame pulse
    send_byte(8'h61, 1'b0);
    send_byte(8'h62, 1'b0);
    send_byte(8'h31, 1'b0);
    chk("ab1_cursor", 32'(cursor), 32'd3);
    chk_line("ab1_before_frame", char_out, '0);
    pulse_frame();
    exp_line = '0;
    exp_line[0] = 8'h41;
    exp_line[1] = 8'h42;
    exp_line[2] = 8'h31;
    chk_line("ab1_after_frame", char_out, exp_line);

    for (int i = 0; i < 10; i++) begin
      send_byte(tbl[i].data, 1'b0);
      chk($sformatf("tbl%0d_cursor", i), 32'(cursor), 32'(tbl[i].cur));
      chk($sformatf("tbl%0d_full", i), 32'(line_full), 32'(tbl[i].full));
    end
    chk_line("tbl_before_frame", char_out, exp_line);
    pulse_frame();
    exp_line[3] = 8'h00;
    exp_line[4] = 8'h5A;
    exp_line[5] = 8'h30;
    chk_line("tbl_after_frame", char_out, exp_line);

    // CR clear with a frame pulse landing mid-CLEAR
    old_line = exp_line;
    send_byte(8'h0D, 1'b0);
    low_cnt = in_ready ? 0 : 1;
    exit_k  = -1;
    partial = 1'b0;
    for (int k = 1; k < 100; k++) begin
      @(negedge clk);
      frame_start = (k == 3);
      @(posedge clk);
      #1;
      frame_start = 1'b0;
      if (char_out !== old_line && char_out !== '0) partial = 1'b1;
      if (exit_k < 0) begin
        if (!in_ready) begin
          low_cnt++;
        end else begin
          exit_k = k;
          chk_line("clear_exit_still_old", char_out, old_line);
          chk("clear_exit_cursor", 32'(cursor), 32'd0);
        end
      end else begin
        chk_line("clear_commit", char_out, '0);
        break;
      end
    end
    chk("clear_ready_low_cycles", 32'(low_cnt), 32'd41);
    chk("clear_never_partial", 32'(partial), 32'd0);

    // write on the same edge as frame_start is visible immediately
    send_byte(8'h41, 1'b1);
    exp_line = '0;
    exp_line[0] = 8'h41;
    chk_line("same_edge_commit", char_out, exp_line);
    send_byte(8'h08, 1'b0);
    chk("bs1_cursor", 32'(cursor), 32'd0);
    send_byte(8'h08, 1'b0);
    chk("bs2_cursor", 32'(cursor), 32'd0);
    pulse_frame();
    chk_line("bs_after_frame", char_out, '0);

    // fill past the end of the line
    for (int i = 1; i <= 42; i++) begin
      send_byte(8'h35, 1'b0);
      if (i == 40) begin
        chk("fill40_cursor", 32'(cursor), 32'd40);
        chk("fill40_full", 32'(line_full), 32'd0);
      end else if (i >= 41) begin
        chk($sformatf("fill%0d_cursor", i), 32'(cursor), 32'd41);
        chk($sformatf("fill%0d_full", i), 32'(line_full), 32'd1);
      end
    end
    chk_line("fill_before_frame", char_out, '0);
    pulse_frame();
    for (int i = 0; i < N; i++) exp_line[i] = 8'h35;
    chk_line("fill_after_frame", char_out, exp_line);
    send_byte(8'h08, 1'b0);
    chk("full_bs_cursor", 32'(cursor), 32'd40);
    chk("full_bs_full", 32'(line_full), 32'd0);

    // LF starts CLEAR; reset lands in the middle of it
    send_byte(8'h0A, 1'b0);
    chk("lf_ready_low", 32'(in_ready), 32'd0);
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_line("midclear_reset_line", char_out, '0);
    chk("midclear_reset_cursor", 32'(cursor), 32'd0);
    chk("midclear_reset_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("midclear_release_ready", 32'(in_ready), 32'd1);
    chk("midclear_release_full", 32'(line_full), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
